// File: rtl/jtsdram_pkg.sv
// -----------------------------------------------------------------------------
// jtsdram_pkg
// Shared definitions for the SDRAM soak-test bank checker:
//   - KEY_W / DW       : address-block key width and data word width
//   - chk_state_e      : access-engine FSM encoding (IDLE, REQ, WAIT, GAP)
//   - exp_data()       : pattern rule shared with the programming stage;
//                        the word stored at an address is seed ^ addr[15:0]
// -----------------------------------------------------------------------------
package jtsdram_pkg;

  localparam int KEY_W = 5;
  localparam int DW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } chk_state_e;

  function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] seed,
                                             input logic [DW-1:0] addr_lo);
    return seed ^ addr_lo;
  endfunction

endpackage

// File: rtl/jtsdram_bank_chk_if.sv
// -----------------------------------------------------------------------------
// jtsdram_bank_chk_if
// One SDRAM bank port as seen by a bank checker.
//   ba_addr  word address            (master -> slave)
//   ba_rd    read request            (master -> slave)
//   ba_wr    write request           (master -> slave)
//   ba_din   write data              (master -> slave)
//   ba_ack   request accepted pulse  (slave -> master)
//   ba_rdy   access complete pulse   (slave -> master)
//   ba_dout  read data, valid with ba_rdy (slave -> master)
// Modports: master (the checker), slave (SDRAM controller / memory model).
// -----------------------------------------------------------------------------
interface jtsdram_bank_chk_if
  import jtsdram_pkg::*;
#(
  parameter int AW = 22
);

  logic [AW-1:0] ba_addr;
  logic          ba_rd;
  logic          ba_wr;
  logic [DW-1:0] ba_din;
  logic          ba_ack;
  logic          ba_rdy;
  logic [DW-1:0] ba_dout;

  modport master (
    output ba_addr, ba_rd, ba_wr, ba_din,
    input  ba_ack, ba_rdy, ba_dout
  );

  modport slave (
    input  ba_addr, ba_rd, ba_wr, ba_din,
    output ba_ack, ba_rdy, ba_dout
  );

endinterface

// File: rtl/jtsdram_chk_addr.sv
// -----------------------------------------------------------------------------
// jtsdram_chk_addr
// Pass counter and address former for one bank checker.
//   clk, rst  clock, synchronous active-high reset
//   clr       restart the pass at access 0 (start accepted)
//   inc       advance to the next access
//   key       key to place in the top address bits (already the latched value)
//   last      current access is the final one of the pass
//   addr_nxt  address of the access the counter is moving to this cycle:
//             {key, 0..., i} with i in the low LEN_W bits
// -----------------------------------------------------------------------------
module jtsdram_chk_addr
  import jtsdram_pkg::*;
#(
  parameter int AW    = 22,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [KEY_W-1:0] key,
  output logic             last,
  output logic [AW-1:0]    addr_nxt
);

  logic [LEN_W-1:0] i_q, i_d;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    i_d = i_q;
    if (clr) begin
      i_d = '0;
    end else if (inc) begin
      i_d = i_q + LEN_W'(1);
    end
  end

  // The registered request address is loaded from the counter's next value,
  // so the address is ready in the same cycle the request is raised.
  always_comb begin
    addr_nxt                  = '0;
    addr_nxt[AW-1 -: KEY_W]   = key;
    addr_nxt[LEN_W-1:0]       = i_d;
  end

  assign last = &i_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
    end else begin
      i_q <= i_d;
    end
  end

endmodule

// File: rtl/jtsdram_bank_chk.sv
// -----------------------------------------------------------------------------
// jtsdram_bank_chk
// Per-bank access engine and data checker for the SDRAM soak test.
// Walks 2^LEN_W addresses {key, 0..., i} on one bank port, either writing
// data_ref ^ addr[15:0] or reading and comparing against it, then raises done.
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle pulse, begins a pass (ignored unless idle)
//   key        address block selector      (latched on start)
//   slow       insert GAP idle cycles      (latched on start)
//   we         1 = write pass, 0 = verify  (latched on start)
//   data_ref   pattern seed                (latched on start)
//   done       idle / pass finished
//   bad        sticky error flag (mismatch or watchdog) since reset
//   err_cnt    saturating mismatch count since reset
//   err_addr   address of the first mismatch since reset
//   ba         bank port (master side of jtsdram_bank_chk_if)
//
// Build option
//   JTSDRAM_CHK_TIMEOUT_EN : TO_W-bit watchdog in REQ/WAIT; on expiry it sets
//                            bad, drops the request and returns to idle.
//                            Without it a missing ack/rdy stalls the engine.
// -----------------------------------------------------------------------------
module jtsdram_bank_chk
  import jtsdram_pkg::*;
#(
  parameter int AW    = 22,
  parameter int LEN_W = 8,
  parameter int GAP   = 4,
  parameter int TO_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic             slow,
  input  logic             we,
  input  logic [DW-1:0]    data_ref,
  output logic             done,
  output logic             bad,
  output logic [DW-1:0]    err_cnt,
  output logic [AW-1:0]    err_addr,
  jtsdram_bank_chk_if.master ba
);

  // Elaboration-time parameter sanity: the key must not overlap the counter,
  // the pattern needs 16 address bits, and the gap counter is 4 bits wide.
  if (LEN_W > AW - KEY_W || AW < DW || GAP < 1 || GAP > 15 || TO_W < 2)
  begin : g_param_chk
    $error("jtsdram_bank_chk: illegal AW/LEN_W/GAP/TO_W combination");
  end

  localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

  chk_state_e       state_q, state_d;
  logic             done_q, done_d;
  logic             bad_q, bad_d;
  logic [DW-1:0]    err_cnt_q, err_cnt_d;
  logic [AW-1:0]    err_addr_q, err_addr_d;
  logic             ba_rd_q, ba_rd_d;
  logic             ba_wr_q, ba_wr_d;
  logic [AW-1:0]    ba_addr_q, ba_addr_d;
  logic [DW-1:0]    ba_din_q, ba_din_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             we_q, we_d;
  logic             slow_q, slow_d;
  logic [DW-1:0]    ref_q, ref_d;
  logic [3:0]       gap_q, gap_d;

  logic             cnt_clr, cnt_inc;
  logic             issue;      // load a new request into the output registers
  logic             drop;       // lower the request (ack seen or watchdog)
  logic             last;
  logic [AW-1:0]    addr_nxt;

`ifdef JTSDRAM_CHK_TIMEOUT_EN
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
`endif

  jtsdram_chk_addr #(
    .AW    (AW),
    .LEN_W (LEN_W)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .key      (key_d),
    .last     (last),
    .addr_nxt (addr_nxt)
  );

  // Control: state, pass parameters and error statistics. Kept apart from the
  // request-register logic below because that logic consumes addr_nxt, which
  // depends on the counter controls produced here.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    bad_d      = bad_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    key_d      = key_q;
    we_d       = we_q;
    slow_d     = slow_q;
    ref_d      = ref_q;
    gap_d      = gap_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    issue      = 1'b0;
    drop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key;
          we_d    = we;
          slow_d  = slow;
          ref_d   = data_ref;
          cnt_clr = 1'b1;
          issue   = 1'b1;
          done_d  = 1'b0;
          state_d = ST_REQ;
        end
      end

      // A ba_rdy coinciding with ba_ack here is deliberately not looked at.
      ST_REQ: begin
        if (ba.ba_ack) begin
          drop    = 1'b1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (ba.ba_rdy) begin
          if (!we_q && ba.ba_dout != exp_data(ref_q, ba_addr_q[DW-1:0])) begin
            bad_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + DW'(1);
            end
            // The count saturates and never returns to zero, so zero means
            // this is the first mismatch since reset.
            if (err_cnt_q == '0) begin
              err_addr_d = ba_addr_q;
            end
          end
          if (last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_inc = 1'b1;
            if (slow_q) begin
              gap_d   = GAP_M1;
              state_d = ST_GAP;
            end else begin
              issue   = 1'b1;
              state_d = ST_REQ;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          issue   = 1'b1;
          state_d = ST_REQ;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef JTSDRAM_CHK_TIMEOUT_EN
    // The counter restarts on every state change; it fires when its next
    // value would be all-ones, i.e. after 2^TO_W-1 cycles in the same state.
    to_cnt_d = '0;
    if ((state_q == ST_REQ || state_q == ST_WAIT) && state_d == state_q) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_d == '1) begin
        bad_d    = 1'b1;
        drop     = 1'b1;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end
    end
`endif
  end

  // Request registers: loaded on issue using the just-latched pass settings,
  // held while waiting for ack, cleared once the request is accepted.
  always_comb begin
    ba_rd_d   = ba_rd_q;
    ba_wr_d   = ba_wr_q;
    ba_addr_d = ba_addr_q;
    ba_din_d  = ba_din_q;
    if (issue) begin
      ba_rd_d   = ~we_d;
      ba_wr_d   = we_d;
      ba_addr_d = addr_nxt;
      ba_din_d  = exp_data(ref_d, addr_nxt[DW-1:0]);
    end else if (drop) begin
      ba_rd_d   = 1'b0;
      ba_wr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b1;
      bad_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      ba_rd_q    <= 1'b0;
      ba_wr_q    <= 1'b0;
      ba_addr_q  <= '0;
      ba_din_q   <= '0;
      key_q      <= '0;
      we_q       <= 1'b0;
      slow_q     <= 1'b0;
      ref_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      ba_rd_q    <= ba_rd_d;
      ba_wr_q    <= ba_wr_d;
      ba_addr_q  <= ba_addr_d;
      ba_din_q   <= ba_din_d;
      key_q      <= key_d;
      we_q       <= we_d;
      slow_q     <= slow_d;
      ref_q      <= ref_d;
      gap_q      <= gap_d;
    end
  end

`ifdef JTSDRAM_CHK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign done       = done_q;
  assign bad        = bad_q;
  assign err_cnt    = err_cnt_q;
  assign err_addr   = err_addr_q;
  assign ba.ba_rd   = ba_rd_q;
  assign ba.ba_wr   = ba_wr_q;
  assign ba.ba_addr = ba_addr_q;
  assign ba.ba_din  = ba_din_q;

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// -----------------------------------------------------------------------------
// tb_jtsdram_bank_chk
// Directed bench for jtsdram_bank_chk with a bank-port memory model that acks
// a request in the cycle it first appears and returns ba_rdy 3 cycles later.
// The model logs every accepted request (address, direction, data, cycle) and
// the cycle of each ba_rdy; the scenario tasks compare those logs and the
// checker outputs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_jtsdram_bank_chk;
  import jtsdram_pkg::*;

  localparam int AW     = 22;
  localparam int LEN_W  = 8;
  localparam int GAP_C  = 4;
  localparam int TO_W   = 10;
  localparam int N      = 256;
  localparam int LAT    = 3;
  localparam int MAXLOG = 320;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [KEY_W-1:0] key = '0;
  logic             slow = 1'b0;
  logic             we = 1'b0;
  logic [DW-1:0]    data_ref = '0;
  logic             done, bad;
  logic [DW-1:0]    err_cnt;
  logic [AW-1:0]    err_addr;

  jtsdram_bank_chk_if #(.AW(AW)) ba_if ();

  jtsdram_bank_chk #(
    .AW(AW), .LEN_W(LEN_W), .GAP(GAP_C), .TO_W(TO_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .slow     (slow),
    .we       (we),
    .data_ref (data_ref),
    .done     (done),
    .bad      (bad),
    .err_cnt  (err_cnt),
    .err_addr (err_addr),
    .ba       (ba_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [AW-1:0] log_addr    [MAXLOG];
  logic          log_rd      [MAXLOG];
  logic          log_wr      [MAXLOG];
  logic [DW-1:0] log_din     [MAXLOG];
  int            log_req_cyc [MAXLOG];
  int            log_rdy_cyc [MAXLOG];
  int            nlog = 0;
  int            lat_cnt = 0;
  int            pend_idx = 0;
  logic [DW-1:0] pend_dout = '0;
  logic [DW-1:0] m_ref = '0;
  bit            hold_ack = 1'b0;
  bit            corrupt_en = 1'b0;
  int            corrupt_idx = 0;

  initial begin
    ba_if.ba_ack  = 1'b0;
    ba_if.ba_rdy  = 1'b0;
    ba_if.ba_dout = '0;
  end

  always @(negedge clk) begin
    ba_if.ba_ack = 1'b0;
    ba_if.ba_rdy = 1'b0;
    if (rst) begin
      lat_cnt = 0;
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        ba_if.ba_rdy  = 1'b1;
        ba_if.ba_dout = pend_dout;
        if (pend_idx < MAXLOG) log_rdy_cyc[pend_idx] = cyc;
      end
    end else if ((ba_if.ba_rd || ba_if.ba_wr) && !hold_ack) begin
      ba_if.ba_ack = 1'b1;
      lat_cnt      = LAT;
      pend_dout    = m_ref ^ ba_if.ba_addr[15:0];
      if (corrupt_en && nlog == corrupt_idx) pend_dout = pend_dout ^ 16'h0100;
      if (nlog < MAXLOG) begin
        log_addr[nlog]    = ba_if.ba_addr;
        log_rd[nlog]      = ba_if.ba_rd;
        log_wr[nlog]      = ba_if.ba_wr;
        log_din[nlog]     = ba_if.ba_din;
        log_req_cyc[nlog] = cyc;
      end
      pend_idx = nlog;
      nlog++;
    end
  end

  // ---------------- helpers (stimulus / waiting only) ----------------
  function automatic logic [AW-1:0] exp_addr(input logic [KEY_W-1:0] k, input int i);
    logic [AW-1:0] a;
    a = '0;
    a[AW-1 -: KEY_W] = k;
    a[LEN_W-1:0] = i[LEN_W-1:0];
    return a;
  endfunction

  // Returns at the negedge right after the edge that sampled start.
  task automatic start_pass(input logic [KEY_W-1:0] k, input logic w, input logic s,
                            input logic [DW-1:0] r, output int t0);
    @(negedge clk);
    #1;
    key = k; we = w; slow = s; data_ref = r; m_ref = r; nlog = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, output int t1);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (done !== 1'b1)  begin n_bad++; $display("FAIL reset_done: got %b want 1", done); end
    n_cmp++; if (bad !== 1'b0)   begin n_bad++; $display("FAIL reset_bad: got %b want 0", bad); end
    n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_err_cnt: got %h want 0000", err_cnt); end
    n_cmp++; if (err_addr !== '0) begin n_bad++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
    n_cmp++; if (ba_if.ba_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %b want 0", ba_if.ba_rd); end
    n_cmp++; if (ba_if.ba_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", ba_if.ba_wr); end
    n_cmp++; if (ba_if.ba_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", ba_if.ba_addr); end
    n_cmp++; if (ba_if.ba_din !== '0) begin n_bad++; $display("FAIL reset_din: got %h want 0", ba_if.ba_din); end
    #1 rst = 1'b0;
  endtask

  task automatic test_read_clean();
    int t0, t1;
    logic [AW-1:0] ea;
    corrupt_en = 1'b0;
    start_pass(5'h1F, 1'b0, 1'b0, 16'hAAAA, t0);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL clean_busy: done=%b want 0", done); end
    wait_done(3000, t1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL clean_done: done=%b want 1", done); end
    n_cmp++; if (t1 - t0 !== 1024) begin n_bad++; $display("FAIL clean_latency: got %0d want 1024", t1 - t0); end
    n_cmp++; if (nlog !== N) begin n_bad++; $display("FAIL clean_count: got %0d want %0d", nlog, N); end
    for (int i = 0; i < N && i < nlog; i++) begin
      ea = exp_addr(5'h1F, i);
      n_cmp++;
      if (log_addr[i] !== ea || log_rd[i] !== 1'b1 || log_wr[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL clean_req[%0d]: addr=%h rd=%b wr=%b want addr=%h rd=1 wr=0",
                 i, log_addr[i], log_rd[i], log_wr[i], ea);
      end
      if (i > 0) begin
        n_cmp++;
        if (log_req_cyc[i] - log_rdy_cyc[i-1] !== 1) begin
          n_bad++;
          $display("FAIL clean_spacing[%0d]: got %0d want 1", i, log_req_cyc[i] - log_rdy_cyc[i-1]);
        end
      end
    end
    n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL clean_err_cnt: got %h want 0000", err_cnt); end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL clean_bad: got %b want 0", bad); end
  endtask

  task automatic test_read_corrupt();
    int t0, t1;
    corrupt_en = 1'b1;
    corrupt_idx = 7;
    start_pass(5'h1F, 1'b0, 1'b0, 16'hAAAA, t0);
    wait_done(3000, t1);
    corrupt_en = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL corrupt_done: done=%b want 1", done); end
    n_cmp++; if (nlog !== N) begin n_bad++; $display("FAIL corrupt_count: got %0d want %0d", nlog, N); end
    n_cmp++; if (bad !== 1'b1) begin n_bad++; $display("FAIL corrupt_bad: got %b want 1", bad); end
    n_cmp++; if (err_cnt !== 16'h0001) begin n_bad++; $display("FAIL corrupt_err_cnt: got %h want 0001", err_cnt); end
    n_cmp++; if (err_addr !== 22'h3E0007) begin n_bad++; $display("FAIL corrupt_err_addr: got %h want 3e0007", err_addr); end
  endtask

  task automatic test_write_slow();
    int t0, t1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    start_pass(5'h1F, 1'b1, 1'b1, 16'hAAAA, t0);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL write_busy: done=%b want 0", done); end
    wait_done(4000, t1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL write_done: done=%b want 1", done); end
    n_cmp++; if (nlog !== N) begin n_bad++; $display("FAIL write_count: got %0d want %0d", nlog, N); end
    for (int i = 0; i < N && i < nlog; i++) begin
      ea = exp_addr(5'h1F, i);
      ed = 16'hAAAA ^ ea[15:0];
      n_cmp++;
      if (log_addr[i] !== ea || log_wr[i] !== 1'b1 || log_rd[i] !== 1'b0 || log_din[i] !== ed) begin
        n_bad++;
        $display("FAIL write_req[%0d]: addr=%h wr=%b rd=%b din=%h want addr=%h wr=1 rd=0 din=%h",
                 i, log_addr[i], log_wr[i], log_rd[i], log_din[i], ea, ed);
      end
      // rdy sampled at edge R; 4 GAP cycles follow; request visible after edge R+4.
      if (i > 0) begin
        n_cmp++;
        if (log_req_cyc[i] - log_rdy_cyc[i-1] !== 1 + GAP_C) begin
          n_bad++;
          $display("FAIL write_gap[%0d]: got %0d want %0d", i, log_req_cyc[i] - log_rdy_cyc[i-1], 1 + GAP_C);
        end
      end
    end
    n_cmp++; if (err_cnt !== 16'h0001) begin n_bad++; $display("FAIL write_err_cnt: got %h want 0001", err_cnt); end
    n_cmp++; if (bad !== 1'b1) begin n_bad++; $display("FAIL write_bad: got %b want 1", bad); end
    n_cmp++; if (err_addr !== 22'h3E0007) begin n_bad++; $display("FAIL write_err_addr: got %h want 3e0007", err_addr); end
  endtask

  task automatic test_start_ignored();
    int t0, t1;
    logic [AW-1:0] ea;
    start_pass(5'h0A, 1'b0, 1'b0, 16'h1234, t0);
    repeat (50) @(negedge clk);
    #1;
    start = 1'b1; key = 5'h15; we = 1'b1; slow = 1'b1; data_ref = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ignore_busy: done=%b want 0", done); end
    wait_done(3000, t1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ignore_done: done=%b want 1", done); end
    n_cmp++; if (t1 - t0 !== 1024) begin n_bad++; $display("FAIL ignore_latency: got %0d want 1024", t1 - t0); end
    n_cmp++; if (nlog !== N) begin n_bad++; $display("FAIL ignore_count: got %0d want %0d", nlog, N); end
    for (int i = 0; i < N && i < nlog; i++) begin
      ea = exp_addr(5'h0A, i);
      n_cmp++;
      if (log_addr[i] !== ea || log_rd[i] !== 1'b1 || log_wr[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL ignore_req[%0d]: addr=%h rd=%b wr=%b want addr=%h rd=1 wr=0",
                 i, log_addr[i], log_rd[i], log_wr[i], ea);
      end
    end
    n_cmp++; if (err_cnt !== 16'h0001) begin n_bad++; $display("FAIL ignore_err_cnt: got %h want 0001", err_cnt); end
  endtask

  task automatic test_reset_mid();
    int t0, t1;
    int n = 0;
    logic [AW-1:0] ea;
    start_pass(5'h03, 1'b0, 1'b0, 16'h5A5A, t0);
    while (!(nlog >= 3 && lat_cnt > 0) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++; if (lat_cnt <= 0) begin n_bad++; $display("FAIL rstmid_reach_wait: not in WAIT after %0d cycles", n); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ba_if.ba_rd !== 1'b0) begin n_bad++; $display("FAIL rstmid_rd: got %b want 0", ba_if.ba_rd); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rstmid_done: got %b want 1", done); end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL rstmid_bad: got %b want 0", bad); end
    n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL rstmid_err_cnt: got %h want 0000", err_cnt); end
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ba_if.ba_rd !== 1'b0 || ba_if.ba_wr !== 1'b0 || done !== 1'b1) begin
        n_bad++;
        $display("FAIL rstmid_trailing[%0d]: rd=%b wr=%b done=%b want 0 0 1", c, ba_if.ba_rd, ba_if.ba_wr, done);
      end
    end
    start_pass(5'h03, 1'b0, 1'b0, 16'h5A5A, t0);
    wait_done(3000, t1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rstmid_pass_done: done=%b want 1", done); end
    n_cmp++; if (nlog !== N) begin n_bad++; $display("FAIL rstmid_pass_count: got %0d want %0d", nlog, N); end
    for (int i = 0; i < N && i < nlog; i++) begin
      ea = exp_addr(5'h03, i);
      n_cmp++;
      if (log_addr[i] !== ea || log_rd[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL rstmid_pass_req[%0d]: addr=%h rd=%b want addr=%h rd=1", i, log_addr[i], log_rd[i], ea);
      end
    end
    n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL rstmid_pass_err_cnt: got %h want 0000", err_cnt); end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL rstmid_pass_bad: got %b want 0", bad); end
  endtask

`ifdef JTSDRAM_CHK_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    int hi = 0;
    int n = 0;
    hold_ack = 1'b1;
    start_pass(5'h02, 1'b0, 1'b0, 16'h0F0F, t0);
    while (done !== 1'b1 && n < 1200) begin
      if (ba_if.ba_rd === 1'b1) hi++;
      @(negedge clk);
      n++;
    end
    hold_ack = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL timeout_done: got %b want 1", done); end
    n_cmp++; if (bad !== 1'b1) begin n_bad++; $display("FAIL timeout_bad: got %b want 1", bad); end
    n_cmp++; if (ba_if.ba_rd !== 1'b0) begin n_bad++; $display("FAIL timeout_rd: got %b want 0", ba_if.ba_rd); end
    n_cmp++; if (hi !== 1023) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d want 1023", hi); end
    n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL timeout_err_cnt: got %h want 0000", err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_clean();
    test_read_corrupt();
    test_write_slow();
    test_start_ignored();
    test_reset_mid();
`ifdef JTSDRAM_CHK_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

endmodule
